sisc_exec_unit: RTL and testbench
=================================

Name: sisc_exec_unit

Overview:
Execution slice of the SISC processor: the control FSM, the 32-bit ALU and the 32-bit write-back mux in one block.
- Takes the current instruction word (IR) and the two register-file read operands.
- Produces the register-file write strobe, the destination-select signal, write-back data, and ALU condition codes with their enable for the external status register.
- Register file, destination mux and status register sit outside this block.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  asynchronous active-low reset
IR  in  32  instruction word: [31:28] opcode, [27:24] funct, [23:20] rs, [19:16] rt, [15:12] rd, [15:0] imm
rsa  in  32  register operand A (rs)
rsb  in  32  register operand B (rt)
rf_we  out  1  register-file write enable
rd_sel  out  1  destination select: 0 = IR[15:12], 1 = IR[19:16]
alu_op  out  2  [0] immediate operand select, [1] ALU instruction active
wb_sel  out  1  write-back select: 1 = alu_result, 0 = 32'h0
alu_result  out  32  ALU output
wb_data  out  32  write-back data
stat  out  4  {C,V,N,Z} from current ALU result
stat_en  out  1  status register load enable

Behaviour:
- State register, async clear on RST_F=0 to START0. All control outputs are Moore decodes of state plus IR opcode.
- Sequence: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH. One state per clock, so 5 cycles per instruction.
- Opcodes:
  - 0000 NOP.
  - 0001 ALU reg: B = rsb, dest IR[15:12].
  - 0010 ALU imm: B = sign-extended IR[15:0], dest IR[19:16].
  - 1111 HLT (see Optional Feature).
  - All others behave as NOP.
- Output activity windows:
  - alu_op[1] = 1 in DECODE, EXECUTE, MEM, WRITEBACK for opcodes 0001/0010.
  - alu_op[0] = 1 in those same states for opcode 0010 only.
  - rd_sel = 1 in those same states for opcode 0010 only.
  - stat_en = 1 only in EXECUTE, for an ALU opcode with a valid funct.
  - wb_sel and rf_we = 1 only in WRITEBACK, for an ALU opcode with a valid funct.
  - All other times these outputs are 0, including during reset and in START0/START1.
- Reset mid-instruction: every output drops to 0 immediately (asynchronously). No write occurs.
- ALU is combinational. A = rsa; B = rsb, or imm when alu_op[0]. Funct IR[27:24]:
  - 0001 ADD.
  - 0010 SUB (A-B).
  - 0011 OR.
  - 0100 AND.
  - 0101 XOR.
  - 0110 NOT A.
  - 0111 SRL A by B[4:0].
  - 1000 SLL A by B[4:0].
  - 1001 ROR A by B[4:0].
  - 1010 ROL A by B[4:0].
  - Any other funct is invalid: result 0, no stat_en, no rf_we.
- Arithmetic is modulo 2^32.
- Flags:
  - C = carry-out for ADD; for SUB, C = NOT borrow, so C=1 when A >= B unsigned.
  - V = signed overflow for ADD/SUB.
  - C and V are 0 for all other functs.
  - N = result[31]; Z = (result == 0).
- Shift amount 0 returns A unchanged.
- wb_data = wb_sel ? alu_result : 32'h0.

Optional Feature:
SISC_HALT_EN:
- Defined: opcode 1111 in DECODE moves the FSM to HALT. HALT is terminal until RST_F, and all outputs are 0 there.
- Undefined: 1111 is a NOP and the FSM continues normally.

Decomposition:
- Package sisc_pkg holds:
  - the opcode localparams;
  - the funct localparams;
  - the state enum (START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT);
  - the flag bit indices.
- One sub-module, sisc_alu: combinational, holds the operand mux, function unit and flags.
- The FSM and write-back mux live in the top.

Test Plan:
- Reset released at t0 -> two START cycles then FETCH; rf_we/stat_en/wb_sel stay 0 throughout; the first possible rf_we pulse lands in the 7th cycle after release.
- IR=0x11120000 (ADD r1,r2 -> r0... rd=0), rsa=5, rsb=7 -> stat_en pulses in EXECUTE with stat=0000; rf_we and wb_sel pulse in WRITEBACK; wb_data=12; rd_sel=0.
- IR=0x2210FFFF (SUB imm, rs=1, rd=0), rsa=0 -> B=0xFFFFFFFF, result 1, stat C=0 V=0 N=0 Z=0; alu_op=11 and rd_sel=1 from DECODE to WRITEBACK.
- ADD with rsa=0x7FFFFFFF, rsb=1 -> result 0x80000000, V=1 N=1 C=0; ADD with rsa=0xFFFFFFFF, rsb=1 -> 0, C=1 Z=1.
- IR with funct 0x9 (ROR), rsa=0x00000001, rsb=1 -> 0x80000000; funct 0xF -> no stat_en, no rf_we, wb_data=0.
- RST_F asserted during EXECUTE -> outputs 0 immediately; restart from START0; with SISC_HALT_EN, opcode 0xF -> FSM stuck, no further rf_we until reset.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC execution slice: opcodes, ALU function codes,
// control FSM states and condition-code bit positions.
// Latency: n/a (definitions only).  Backpressure: n/a.
package sisc_pkg;

  localparam int DATA_W_C = 32;

  // Opcodes, IR[31:28]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU_R = 4'h1;
  localparam logic [3:0] OP_ALU_I = 4'h2;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // ALU function codes, IR[27:24]
  localparam logic [3:0] FN_ADD = 4'h1;
  localparam logic [3:0] FN_SUB = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;
  localparam logic [3:0] FN_AND = 4'h4;
  localparam logic [3:0] FN_XOR = 4'h5;
  localparam logic [3:0] FN_NOT = 4'h6;
  localparam logic [3:0] FN_SRL = 4'h7;
  localparam logic [3:0] FN_SLL = 4'h8;
  localparam logic [3:0] FN_ROR = 4'h9;
  localparam logic [3:0] FN_ROL = 4'hA;

  // Bit positions inside the 4-bit {C,V,N,Z} status word
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    START0,
    START1,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT
  } state_e;

  // Function codes form one contiguous range ADD..ROL.
  function automatic logic funct_valid(input logic [3:0] f);
    return (f >= FN_ADD) && (f <= FN_ROL);
  endfunction

  function automatic logic is_alu_opcode(input logic [3:0] op);
    return (op == OP_ALU_R) || (op == OP_ALU_I);
  endfunction

endpackage

// File: rtl/sisc_exec_unit_if.sv
// Instruction/operand inputs and write-back/status outputs of the SISC execution slice.
// Latency: n/a (wires only).  Backpressure: none, the block follows the FSM cadence.
// master: drives IR/rsa/rsb and observes results; slave: the execution unit.
interface sisc_exec_unit_if #(
  parameter int DATA_W = 32
) ();
  logic [31:0]       IR;
  logic [DATA_W-1:0] rsa;
  logic [DATA_W-1:0] rsb;
  logic              rf_we;
  logic              rd_sel;
  logic [1:0]        alu_op;
  logic              wb_sel;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        stat;
  logic              stat_en;

  modport master (
    output IR, rsa, rsb,
    input  rf_we, rd_sel, alu_op, wb_sel, alu_result, wb_data, stat, stat_en
  );

  modport slave (
    input  IR, rsa, rsb,
    output rf_we, rd_sel, alu_op, wb_sel, alu_result, wb_data, stat, stat_en
  );
endinterface

// File: rtl/sisc_alu.sv
// Combinational 32-bit ALU: B-operand mux, function unit and {C,V,N,Z} flags.
// Latency: 0 cycles (purely combinational).  Backpressure: none.
// Ports: a_i/b_i register operands, imm_i sign-extended immediate, imm_sel_i picks imm
//        for B, funct_i function code; result_o result, stat_o {C,V,N,Z}.
module sisc_alu
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              imm_sel_i,
  input  logic [3:0]        funct_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        stat_o
);

  logic [DATA_W-1:0]   b_op;
  logic [DATA_W:0]     add_w;
  logic [DATA_W:0]     sub_w;
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] rot_r;
  logic [2*DATA_W-1:0] rot_l;
  logic                c_flag;
  logic                v_flag;

  always_comb begin
    b_op = imm_sel_i ? imm_i : b_i;
    add_w = {1'b0, a_i} + {1'b0, b_op};
    // A + ~B + 1: the carry out is the inverted borrow, so C=1 exactly when A >= B.
    sub_w = {1'b0, a_i} + {1'b0, ~b_op} + {{DATA_W{1'b0}}, 1'b1};
    sh    = b_op[4:0];
    // Rotations via a doubled word; the low (right) or high (left) half is the result,
    // which also yields A unchanged for a zero shift.
    rot_r = {a_i, a_i} >> sh;
    rot_l = {a_i, a_i} << sh;

    result_o = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    unique case (funct_i)
      FN_ADD: begin
        result_o = add_w[DATA_W-1:0];
        c_flag   = add_w[DATA_W];
        v_flag   = (a_i[DATA_W-1] == b_op[DATA_W-1]) &&
                   (add_w[DATA_W-1] != a_i[DATA_W-1]);
      end
      FN_SUB: begin
        result_o = sub_w[DATA_W-1:0];
        c_flag   = sub_w[DATA_W];
        v_flag   = (a_i[DATA_W-1] != b_op[DATA_W-1]) &&
                   (sub_w[DATA_W-1] != a_i[DATA_W-1]);
      end
      FN_OR:   result_o = a_i | b_op;
      FN_AND:  result_o = a_i & b_op;
      FN_XOR:  result_o = a_i ^ b_op;
      FN_NOT:  result_o = ~a_i;
      FN_SRL:  result_o = a_i >> sh;
      FN_SLL:  result_o = a_i << sh;
      FN_ROR:  result_o = rot_r[DATA_W-1:0];
      FN_ROL:  result_o = rot_l[2*DATA_W-1:DATA_W];
      default: result_o = '0;
    endcase

    stat_o         = '0;
    stat_o[FLAG_C] = c_flag;
    stat_o[FLAG_V] = v_flag;
    stat_o[FLAG_N] = result_o[DATA_W-1];
    stat_o[FLAG_Z] = (result_o == '0);
  end

endmodule

// File: rtl/sisc_exec_unit.sv
// SISC execution slice: control FSM, ALU and write-back mux.
// Latency: 5 cycles per instruction (FETCH..WRITEBACK), two START cycles after reset.
// Backpressure: none; IR/operands must be held stable from DECODE through WRITEBACK.
// Ports: CLK, RST_F (async active-low), bus (slave modport: IR/rsa/rsb in; rf_we,
//        rd_sel, alu_op, wb_sel, alu_result, wb_data, stat, stat_en out).
// Build option: define SISC_HALT_EN to make opcode 1111 a terminal halt.
module sisc_exec_unit
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic             CLK,
  input  logic             RST_F,
  sisc_exec_unit_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  logic [3:0]        opcode;
  logic [3:0]        funct;
  logic              is_alu;
  logic              is_imm;
  logic              fn_ok;
  logic              in_window;
  logic              wb_sel_w;
  logic [1:0]        alu_op_w;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_stat;
  logic              unused_ir_regs;

  assign opcode  = bus.IR[31:28];
  assign funct   = bus.IR[27:24];
  assign imm_ext = {{(DATA_W-16){bus.IR[15]}}, bus.IR[15:0]};
  // Register specifiers go straight to the external register file.
  assign unused_ir_regs = ^bus.IR[23:16];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START0:    state_d = START1;
      START1:    state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE: begin
        state_d = EXECUTE;
`ifdef SISC_HALT_EN
        if (opcode == OP_HLT) state_d = HALT;
`endif
      end
      EXECUTE:   state_d = MEM;
      MEM:       state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = START0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) state_q <= START0;
    else        state_q <= state_d;
  end

  // Outputs decode state plus the live opcode; the async clear of state_q forces
  // them all low the moment RST_F falls.
  assign is_alu    = is_alu_opcode(opcode);
  assign is_imm    = (opcode == OP_ALU_I);
  assign fn_ok     = funct_valid(funct);
  assign in_window = (state_q == DECODE) || (state_q == EXECUTE) ||
                     (state_q == MEM)    || (state_q == WRITEBACK);
  assign alu_op_w  = {in_window & is_alu, in_window & is_imm};
  assign wb_sel_w  = (state_q == WRITEBACK) & is_alu & fn_ok;

  sisc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i       (bus.rsa),
    .b_i       (bus.rsb),
    .imm_i     (imm_ext),
    .imm_sel_i (alu_op_w[0]),
    .funct_i   (funct),
    .result_o  (alu_result),
    .stat_o    (alu_stat)
  );

  assign bus.alu_op     = alu_op_w;
  assign bus.rd_sel     = alu_op_w[0];
  assign bus.stat_en    = (state_q == EXECUTE) & is_alu & fn_ok;
  assign bus.wb_sel     = wb_sel_w;
  assign bus.rf_we      = wb_sel_w;
  assign bus.alu_result = alu_result;
  assign bus.stat       = alu_stat;
  assign bus.wb_data    = wb_sel_w ? alu_result : '0;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Testbench for sisc_exec_unit: directed instructions, scoreboard of expected
// stat_en / rf_we events, monitor compares on every event.
module tb_sisc_exec_unit;

  logic clk;
  logic rst_f;
  int   cyc;
  int   k;
  int   n_checks;
  int   n_fail;

  typedef struct {
    bit          is_wb;
    int          at_cyc;
    logic [31:0] val;
    logic [3:0]  st;
    logic [1:0]  aop;
    logic        rsel;
  } exp_t;

  exp_t sb[$];

  sisc_exec_unit_if #(.DATA_W(32)) bus ();

  sisc_exec_unit #(.DATA_W(32)) dut (
    .CLK   (clk),
    .RST_F (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: 0 = START0, 2 = first FETCH, 6 = first WRITEBACK.
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 32'({bus.rf_we, bus.rd_sel, bus.alu_op, bus.wb_sel, bus.stat_en}), 32'h0);
    chk({nm, "_wb"}, bus.wb_data, 32'h0);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 100; i++) begin
      if (cyc == target) break;
      @(negedge clk);
    end
    if (cyc != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, target);
    end
  endtask

  // Monitor: every stat_en / rf_we pulse must match the head of the scoreboard.
  exp_t e;
  always @(negedge clk) begin
    if (rst_f && (bus.stat_en || bus.rf_we)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got stat_en=%0b rf_we=%0b expected none (cyc %0d)",
                 bus.stat_en, bus.rf_we, cyc);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", 32'(bus.rf_we), 32'(e.is_wb));
        chk("ev_cyc", cyc, e.at_cyc);
        chk("ev_aluop", 32'(bus.alu_op), 32'(e.aop));
        chk("ev_rdsel", 32'(bus.rd_sel), 32'(e.rsel));
        if (e.is_wb) begin
          chk("wb_data", bus.wb_data, e.val);
          chk("wb_sel", 32'(bus.wb_sel), 32'h1);
        end else begin
          chk("alu_result", bus.alu_result, e.val);
          chk("stat", 32'(bus.stat), 32'(e.st));
        end
      end
    end
  end

  // One instruction in slot k: FETCH at 2+5k, EXECUTE at 4+5k, WRITEBACK at 6+5k.
  task automatic run_instr(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] st, input bit ok);
    int         fe;
    logic [3:0] op;
    logic [1:0] aop;
    exp_t       x;
    fe  = 2 + 5 * k;
    op  = ir[31:28];
    aop = (op == 4'h2) ? 2'b11 : (op == 4'h1) ? 2'b10 : 2'b00;
    wait_cyc(fe);
    chk("fetch_idle", 32'({bus.alu_op, bus.rd_sel, bus.stat_en, bus.rf_we}), 32'h0);
    bus.IR  = ir;
    bus.rsa = a;
    bus.rsb = b;
    if (ok) begin
      x = '{is_wb: 1'b0, at_cyc: fe + 2, val: res, st: st, aop: aop, rsel: aop[0]};
      sb.push_back(x);
      x = '{is_wb: 1'b1, at_cyc: fe + 4, val: res, st: st, aop: aop, rsel: aop[0]};
      sb.push_back(x);
    end
    wait_cyc(fe + 2);
    chk("exec_aluop", 32'(bus.alu_op), 32'(aop));
    if (!ok) chk("inv_stat_en", 32'(bus.stat_en), 32'h0);
    wait_cyc(fe + 4);
    if (!ok) begin
      chk("inv_rf_we", 32'(bus.rf_we), 32'h0);
      chk("inv_wb_data", bus.wb_data, 32'h0);
    end
    k++;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    k = 0;
    rst_f = 1'b1;
    #1;
    chk_idle("start0");
    @(negedge clk);
    wait_cyc(1);
    chk_idle("start1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    rst_f    = 1'b0;
    bus.IR   = 32'h0;
    bus.rsa  = 32'h0;
    bus.rsb  = 32'h0;
    #1;
    chk_idle("reset");
    release_reset();

    //        IR            rsa           rsb           result        CVNZ     ok
    run_instr(32'h11120000, 32'd5,        32'd7,        32'd12,       4'b0000, 1'b1); // ADD
    run_instr(32'h2210FFFF, 32'd0,        32'h12345678, 32'd1,        4'b0000, 1'b1); // SUB imm -1
    run_instr(32'h11120000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110, 1'b1); // ADD ovf
    run_instr(32'h11120000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1001, 1'b1); // ADD carry
    run_instr(32'h12120000, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b0010, 1'b1); // SUB borrow
    run_instr(32'h12120000, 32'd7,        32'd5,        32'd2,        4'b1000, 1'b1); // SUB no borrow
    run_instr(32'h12120000, 32'd9,        32'd9,        32'd0,        4'b1001, 1'b1); // SUB equal
    run_instr(32'h12120000, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b1100, 1'b1); // SUB ovf
    run_instr(32'h13120000, 32'hF0,       32'h0F,       32'hFF,       4'b0000, 1'b1); // OR
    run_instr(32'h14120000, 32'hF0,       32'h3C,       32'h30,       4'b0000, 1'b1); // AND
    run_instr(32'h15120000, 32'hFF,       32'h0F,       32'hF0,       4'b0000, 1'b1); // XOR
    run_instr(32'h16120000, 32'h0,        32'h5,        32'hFFFFFFFF, 4'b0010, 1'b1); // NOT
    run_instr(32'h17120000, 32'h80000000, 32'd4,        32'h08000000, 4'b0000, 1'b1); // SRL
    run_instr(32'h18120000, 32'd1,        32'd31,       32'h80000000, 4'b0010, 1'b1); // SLL 31
    run_instr(32'h18120000, 32'h0000ABCD, 32'h20,       32'h0000ABCD, 4'b0000, 1'b1); // SLL 0
    run_instr(32'h19120000, 32'd1,        32'd1,        32'h80000000, 4'b0010, 1'b1); // ROR
    run_instr(32'h1A120000, 32'h80000000, 32'd1,        32'h00000001, 4'b0000, 1'b1); // ROL
    run_instr(32'h29100004, 32'h12345678, 32'h0,        32'h81234567, 4'b0010, 1'b1); // ROR imm
    run_instr(32'h2110FFFE, 32'd10,       32'h0,        32'd8,        4'b1000, 1'b1); // ADD imm -2
    run_instr(32'h1F120000, 32'd5,        32'd7,        32'h0,        4'b0000, 1'b0); // bad funct F
    run_instr(32'h10120000, 32'd5,        32'd7,        32'h0,        4'b0000, 1'b0); // bad funct 0
    run_instr(32'h00000000, 32'd5,        32'd7,        32'h0,        4'b0000, 1'b0); // NOP
    run_instr(32'h31120000, 32'd5,        32'd7,        32'h0,        4'b0000, 1'b0); // undefined op
    run_instr(32'hF1120000, 32'd5,        32'd7,        32'h0,        4'b0000, 1'b0); // HLT

`ifdef SISC_HALT_EN
    // Halted: a valid instruction must never get to write.
    bus.IR  = 32'h11120000;
    bus.rsa = 32'd1;
    bus.rsb = 32'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("halt_idle", 32'({bus.alu_op, bus.rf_we, bus.stat_en}), 32'h0);
    end
    rst_f = 1'b0;
    release_reset();
`else
    // Opcode F acted as a NOP; the next slot must run on schedule.
    run_instr(32'h11120000, 32'd20,       32'd22,       32'd42,       4'b0000, 1'b1);
`endif

    // Reset during EXECUTE: outputs drop at once, the write never happens.
    begin
      int fe;
      fe = 2 + 5 * k;
      wait_cyc(fe);
      bus.IR  = 32'h11120000;
      bus.rsa = 32'd5;
      bus.rsb = 32'd7;
      x = '{is_wb: 1'b0, at_cyc: fe + 2, val: 32'd12, st: 4'b0000, aop: 2'b10, rsel: 1'b0};
      sb.push_back(x);
      wait_cyc(fe + 2);
      #2;
      rst_f = 1'b0;
      #1;
      chk_idle("rst_async");
      release_reset();
    end

    run_instr(32'h11120000, 32'd100,      32'd23,       32'd123,      4'b0000, 1'b1);
    wait_cyc(2 + 5 * k);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
